// File: rtl/shift_register_sipo.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_sipo
// Description : Serial-in parallel-out deserializer. Bits are sampled one per
//               advance strobe and counted into a word. Each completed word is
//               moved into a holding register and offered on a valid/ready
//               handshake. A sticky overrun flag records any completed word
//               that had to be dropped because the holding register was full.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_sipo #(
    parameter int               WIDTH         = 8,
    parameter bit               MSB_FIRST     = 1'b0,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     advance_i,
    input  logic                     bit_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     overrun_o,
    output logic [$clog2(WIDTH)-1:0] count_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Architectural state.
    logic [WIDTH-1:0] sr_q,      sr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    // Shift register contents after sampling bit_i this cycle. On the
    // completing advance this is the finished word, including the last bit.
    logic [WIDTH-1:0] sr_shift;

    // Bit order on the line decides which end of the register new bits enter.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shift = {sr_q[WIDTH-2:0], bit_i};
        end else begin : g_lsb_first
            assign sr_shift = {bit_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Handshake decode: a pop happens only while a word is actually held,
    // and a word completes on the advance that fills the last bit position.
    logic pop;
    logic complete;

    assign pop      = valid_q && ready_i;
    assign complete = advance_i && (cnt_q == CNT_LAST);

    // Next-state logic. clear_i wins over everything; otherwise advance and
    // the consumer handshake are resolved together so that a pop and a new
    // completion on the same edge hand over without a bubble.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clear_i) begin
            // Abort: drop the partial word, the held word and the overrun
            // flag. The holding register keeps its last value on purpose.
            sr_d      = '0;
            cnt_d     = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (advance_i) begin
                sr_d  = sr_shift;
                cnt_d = complete ? '0 : (cnt_q + CNT_ONE);
            end

            if (complete) begin
                if (!valid_q || pop) begin
                    // Holding register is free (or being freed this edge).
                    data_d  = sr_shift;
                    valid_d = 1'b1;
                end else begin
                    // Consumer stalled: keep the old word, flag the loss.
                    overrun_d = 1'b1;
                end
            end else if (pop) begin
                valid_d = 1'b0;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            data_q    <= DEFAULT_VALUE;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // All outputs come straight from flops.
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign count_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_sipo
// Description : Directed bench for shift_register_sipo. Three instances:
//               8-bit LSB-first, 8-bit MSB-first (non-zero default) sharing
//               one stimulus stream, and a 5-bit LSB-first instance fed by a
//               PISO model. Expected words are queued when stimulus is sent
//               and popped when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_sipo;

    logic clk;
    logic rst_n;
    logic clear;
    logic adv;
    logic bitv;
    logic ready;
    logic adv5;
    logic bit5;
    logic ready5;

    logic [7:0] data8,  data8m;
    logic       valid8, valid8m;
    logic       ovr8,   ovr8m;
    logic [2:0] count8, count8m;
    logic [4:0] data5;
    logic       valid5, ovr5;
    logic [2:0] count5;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp8[$];
    logic [7:0] exp8m[$];
    logic [4:0] exp5[$];

    shift_register_sipo #(.WIDTH(8), .MSB_FIRST(1'b0), .DEFAULT_VALUE(8'h00)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .advance_i(adv), .bit_i(bitv),
        .data_o(data8), .valid_o(valid8), .ready_i(ready), .overrun_o(ovr8), .count_o(count8)
    );

    shift_register_sipo #(.WIDTH(8), .MSB_FIRST(1'b1), .DEFAULT_VALUE(8'h5A)) dut8m (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .advance_i(adv), .bit_i(bitv),
        .data_o(data8m), .valid_o(valid8m), .ready_i(ready), .overrun_o(ovr8m), .count_o(count8m)
    );

    shift_register_sipo #(.WIDTH(5), .MSB_FIRST(1'b0), .DEFAULT_VALUE(5'h0A)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .advance_i(adv5), .bit_i(bit5),
        .data_o(data5), .valid_o(valid5), .ready_i(ready5), .overrun_o(ovr5), .count_o(count5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the scoreboard for both 8-bit instances and compare the held word.
    task automatic check_out8(input string tag);
        chk({tag, "_sb"}, 32'((exp8.size() != 0) && (exp8m.size() != 0)), 32'd1);
        if (exp8.size() != 0 && exp8m.size() != 0) begin
            chk({tag, "_data"},  32'(data8),  32'(exp8.pop_front()));
            chk({tag, "_datam"}, 32'(data8m), 32'(exp8m.pop_front()));
        end
        chk({tag, "_valid"},  32'(valid8),  32'd1);
        chk({tag, "_validm"}, 32'(valid8m), 32'd1);
    endtask

    // Send one 8-bit word, time-order bit i = v[i]. The LSB-first instance
    // rebuilds v, the MSB-first one its bit reverse.
    task automatic send8(input string tag, input logic [7:0] v, input bit accept,
                         input bit rdy_on_last, input bit chk_after);
        if (accept) begin
            exp8.push_back(v);
            exp8m.push_back(rev8(v));
        end
        for (int i = 0; i < 8; i++) begin
            bitv = v[i];
            adv  = 1'b1;
            if (rdy_on_last) ready = (i == 7);
            chk({tag, "_cnt"}, 32'(count8), 32'(i));
            tick();
        end
        adv  = 1'b0;
        bitv = 1'b0;
        if (rdy_on_last) ready = 1'b0;
        if (chk_after) begin
            check_out8(tag);
            chk({tag, "_ovr"}, 32'(ovr8), 32'd0);
        end
    endtask

    task automatic consume8();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        logic [7:0] piso8;
        logic [4:0] piso5;

        rst_n  = 1'b1;
        clear  = 1'b0;
        adv    = 1'b0;
        bitv   = 1'b0;
        ready  = 1'b0;
        adv5   = 1'b0;
        bit5   = 1'b0;
        ready5 = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data8",  32'(data8),  32'h00);
        chk("rst_data8m", 32'(data8m), 32'h5A);
        chk("rst_data5",  32'(data5),  32'h0A);
        chk("rst_valid8", 32'(valid8), 32'd0);
        chk("rst_ovr8",   32'(ovr8),   32'd0);
        chk("rst_cnt8",   32'(count8), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // LSB-first / MSB-first 0xA5 (palindrome), consumer stalled
        send8("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        check_out8("a5");
        chk("a5_cnt_wrap", 32'(count8), 32'd0);
        chk("a5_cnt_wrapm", 32'(count8m), 32'd0);
        consume8();
        chk("a5_pop_valid",  32'(valid8),  32'd0);
        chk("a5_pop_validm", 32'(valid8m), 32'd0);

        // 0x01 LSB-first, 0x80 MSB-first
        send8("w01", 8'h01, 1'b1, 1'b0, 1'b1);
        consume8();

        // Overrun: two words back to back, nobody reading
        send8("ov1", 8'h3C, 1'b1, 1'b0, 1'b0);
        send8("ov2", 8'hC3, 1'b0, 1'b0, 1'b0);
        check_out8("ov");
        chk("ov_flag",  32'(ovr8),  32'd1);
        chk("ov_flagm", 32'(ovr8m), 32'd1);
        consume8();
        chk("ov_pop_valid",  32'(valid8), 32'd0);
        chk("ov_pop_sticky", 32'(ovr8),   32'd1);

        // Clear drops overrun and partial bits but keeps the held value
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovr",  32'(ovr8),   32'd0);
        chk("clr_data", 32'(data8),  32'h3C);
        for (int i = 0; i < 3; i++) begin
            bitv = 1'b1;
            adv  = 1'b1;
            tick();
        end
        adv = 1'b0;
        chk("clr_cnt3", 32'(count8), 32'd3);
        clear = 1'b1;
        adv   = 1'b1;
        tick();
        clear = 1'b0;
        adv   = 1'b0;
        chk("clr_cnt0",  32'(count8), 32'd0);
        chk("clr_valid", 32'(valid8), 32'd0);
        send8("w81", 8'h81, 1'b1, 1'b0, 1'b1);
        consume8();

        // Streaming with a consumer that is always ready
        ready = 1'b1;
        send8("s00", 8'h00, 1'b1, 1'b0, 1'b1);
        send8("sff", 8'hFF, 1'b1, 1'b0, 1'b1);
        send8("s5a", 8'h5A, 1'b1, 1'b0, 1'b1);
        tick();
        ready = 1'b0;
        chk("s_drain_valid", 32'(valid8), 32'd0);
        chk("s_ovr",         32'(ovr8),   32'd0);

        // Pop exactly on the completion edge: no bubble, no overrun
        send8("r12", 8'h12, 1'b1, 1'b0, 1'b1);
        send8("r34", 8'h34, 1'b1, 1'b1, 1'b1);
        consume8();

        // PISO loopback, 8 bits
        piso8 = 8'hA5;
        exp8.push_back(8'hA5);
        exp8m.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            bitv = piso8[0];
            adv  = 1'b1;
            tick();
            piso8 = {1'b0, piso8[7:1]};
        end
        adv = 1'b0;
        check_out8("lb8");

        // Asynchronous reset mid-word, applied between clock edges
        for (int i = 0; i < 3; i++) begin
            bitv = 1'b1;
            adv  = 1'b1;
            tick();
        end
        adv = 1'b0;
        chk("mr_cnt3", 32'(count8), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_data8",  32'(data8),   32'h00);
        chk("mr_data8m", 32'(data8m),  32'h5A);
        chk("mr_valid8", 32'(valid8),  32'd0);
        chk("mr_cnt8",   32'(count8),  32'd0);
        #2 rst_n = 1'b1;
        tick();
        send8("mr96", 8'h96, 1'b1, 1'b0, 1'b1);
        consume8();

        // PISO loopback, 5 bits, non power-of-two wrap
        piso5 = 5'h13;
        exp5.push_back(5'h13);
        for (int i = 0; i < 5; i++) begin
            bit5 = piso5[0];
            adv5 = 1'b1;
            chk("lb5_cnt", 32'(count5), 32'(i));
            tick();
            piso5 = {1'b0, piso5[4:1]};
        end
        adv5 = 1'b0;
        chk("lb5_sb", 32'(exp5.size()), 32'd1);
        if (exp5.size() != 0) chk("lb5_data", 32'(data5), 32'(exp5.pop_front()));
        chk("lb5_valid", 32'(valid5), 32'd1);
        chk("lb5_wrap",  32'(count5), 32'd0);
        chk("lb5_ovr",   32'(ovr5),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_register_sipo.md
# shift_register_sipo

Serial-in parallel-out deserializer: the receive-side counterpart of the team's parallel-in serial-out shift register. It samples one bit per `advance_i` strobe and counts bits into a word. When a word is complete it is moved into an output holding register and presented on a valid/ready handshake. A loopback of this block against the PISO (`bit_o` → `bit_i`, shared advance strobe) with `MSB_FIRST=0` reconstructs the loaded word unchanged.

## Interface
- `WIDTH`, 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 0: bit order on the serial input.
  - 0: first bit received lands in bit 0 (LSB-first, matches the PISO).
  - 1: first bit received lands in bit WIDTH-1.
- `DEFAULT_VALUE`, 0: value of `data_o` after reset.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  synchronous abort. Discards the partial word, the held word and the overrun flag. Takes precedence over `advance_i`.
- `advance_i`  in  1  sample `bit_i` on this edge.
- `bit_i`  in  1  serial data input.
- `data_o`  out  WIDTH  last completed word (holding register).
- `valid_o`  out  1  `data_o` holds an unconsumed word.
- `ready_i`  in  1  consumer accepts `data_o` when `valid_o && ready_i`.
- `overrun_o`  out  1  sticky: a completed word was dropped.
- `count_o`  out  $clog2(WIDTH)  bits received into the current partial word, range 0..WIDTH-1.

## Operation
- State:
  - Shift register `sr[WIDTH-1:0]`.
  - Bit counter `cnt`.
  - Holding register `data_o`.
  - Flags `valid_o` and `overrun_o`.
- Reset (async assert, `rst_ni` low): `sr`=0, `cnt`=0, `data_o`=DEFAULT_VALUE, `valid_o`=0, `overrun_o`=0.
- Precedence per edge: `clear_i` > `advance_i` > hold.
- `clear_i`:
  - `sr`=0, `cnt`=0, `valid_o`=0, `overrun_o`=0.
  - `data_o` keeps its value.
  - `ready_i` is ignored that cycle.
- Shift on `advance_i`:
  - MSB_FIRST=0: `sr` ← {`bit_i`, `sr[WIDTH-1:1]`}.
  - MSB_FIRST=1: `sr` ← {`sr[WIDTH-2:0]`, `bit_i`}.
- Counting: `cnt` increments on each advance. The advance with `cnt`==WIDTH-1 is the completing advance: `cnt` wraps to 0 and the shifted value, including the current `bit_i`, is the completed word `w`.
- Handshake at the edge, with `pop` = `valid_o && ready_i`:
  - Completion and (`!valid_o` or `pop`): `data_o` ← `w`, `valid_o` ← 1.
  - Completion while `valid_o && !ready_i`: `w` is discarded, `data_o` unchanged, `valid_o` stays 1, `overrun_o` ← 1.
  - No completion and `pop`: `valid_o` ← 0, `data_o` unchanged.
- `overrun_o` is cleared only by reset or `clear_i`.
- `ready_i` has no effect while `valid_o`=0.
- `sr` is not cleared on completion. Its contents are don't-care once the next word's bits have displaced them.

## Timing
- Latency: the word is visible on `data_o` with `valid_o`=1 in the cycle after the completing advance edge. No combinational path from `bit_i` or `advance_i` to any output.
- `count_o` is registered and reflects advances up to the previous edge.
- Back-to-back words: `advance_i` may be high every cycle. A consumer holding `ready_i`=1 never causes overrun. With `ready_i`=0 the first word is held and the second completion raises overrun.
- Simultaneous completion and pop on the same edge: the old word is consumed, the new word loads, and `valid_o` stays 1 (no bubble).
- Reset mid-word: partial bits are lost and the next advance counts as bit 0.
- `clear_i` mid-word behaves the same way, synchronously.
- WIDTH not a power of two (e.g. 5): `cnt` wraps at 4→0 and never reaches 5..7.

## Test plan
- LSB-first 0xA5 (WIDTH=8, MSB_FIRST=0):
  - Stimulus: `bit_i` = 1,0,1,0,0,1,0,1 on 8 consecutive advances, `ready_i`=0.
  - Response: `data_o`=0xA5 and `valid_o`=1 one cycle after the 8th advance; `count_o` goes 0..7 then 0.
- MSB-first 0xA5 (MSB_FIRST=1):
  - Stimulus: `bit_i` = 1,0,1,0,0,1,0,1.
  - Response: `data_o`=0xA5.
  - With the same stimulus, MSB_FIRST=0 gives 0xA5 (palindrome check). Also check 0x01 sent LSB-first yields 0x01, and the same bits with MSB_FIRST=1 yield 0x80.
- Overrun:
  - Stimulus: 0x3C then 0xC3 back-to-back with `ready_i`=0.
  - Response: `data_o`=0x3C, `valid_o`=1, `overrun_o`=1 after the 16th advance.
  - Then `ready_i`=1 for one cycle: `valid_o`=0, `overrun_o` still 1.
- Streaming:
  - Stimulus: words 0x00, 0xFF, 0x5A with continuous advance and `ready_i`=1.
  - Response: each word appears in order one cycle after its completing advance; `overrun_o` stays 0. Repeat with `ready_i` asserted exactly on the completion edge and confirm `valid_o` does not drop.
- Clear and reset mid-word:
  - `clear_i` after 3 advances: `count_o`=0 and `valid_o`=0. The next 8 advances of 0x81 give `data_o`=0x81.
  - `rst_ni` pulsed low mid-word between edges: outputs go to reset values immediately, with `data_o`=DEFAULT_VALUE.
- PISO loopback:
  - Stimulus: PISO loaded with 0xA5, its `bit_o` fed to `bit_i` with a shared advance strobe.
  - Response: after 8 advances `data_o`=0xA5.
  - Repeat with WIDTH=5, value 0x13.
